ppe_ifmap_fetch: RTL and testbench
==================================

// Module: ppe_ifmap_fetch
// PURPOSE
// - Requester side of the IFMAP-memory protocol; one instance per PPE (PE_ID 5..9).
// - Accepts 25-bit ifmap rows from the router and double-buffers them.
// - Streams FILTER_SIZE-bit sliding windows to the PPE MAC datapath.
// - Issues one "request next row" packet to IFMAP memory whenever the shadow buffer is free.
// - Clocked block; a CSP-to-clocked wrapper sits on the router side.
// PARAMETERS
// PE_ID        5   own router address; also the request opcode sent to IFMAP memory
// IMEM_ID      11  router address of IFMAP memory
// IFMAP_SIZE   25  row width in bits (one spike bit per column)
// FILTER_SIZE  5   window width
// OUTPUT_SIZE  21  IFMAP_SIZE-FILTER_SIZE+1; windows per row and rows per timestep
// PKT_W        33  packet width: [32:29] dest, [28:25] opcode, [24:0] data
// PORTS
// clk           in   1      single clock, rising edge
// rst_n         in   1      asynchronous, active-low reset
// pkt_in        in   PKT_W  packet from router
// pkt_in_valid  in   1      pkt_in handshake
// pkt_in_ready  out  1      combinational: ~shd_valid
// pkt_out       out  PKT_W  request packet to router
// pkt_out_valid out  1      registered
// pkt_out_ready in   1      router accepts pkt_out
// win_data      out  5      win_data[k] = current row bit (win_col+k)
// win_col       out  5      window column, 0..20
// win_row       out  5      rows consumed this timestep, 0..20
// win_last      out  1      win_col==20 && win_row==20
// win_valid     out  1      equals cur_valid
// win_ready     in   1      MAC datapath consumes window
// ts_done       out  1      1-cycle pulse after the last window of a timestep
// err_pkt       out  1      1-cycle pulse when a bad packet is dropped
// BEHAVIOUR
// - Reset: all registered outputs, cur/shd buffers and flags, and counters go to 0. FSM=IDLE.
//   pkt_in_ready=1. A reset mid-row abandons the row and any outstanding request.
// - Packet check:
//   - Accepted packet must have dest==PE_ID and opcode==1 (PPE_INPUT).
//   - Any other packet is still handshaken, then dropped; err_pkt pulses and no state changes.
// - Load rule on pkt_in handshake:
//   - Write to cur if cur is empty after this cycle's window consumption (same-cycle bypass).
//   - Otherwise write to shd.
//   - rows_rcvd++.
// - Window: win_data = cur[win_col +: FILTER_SIZE]. Latency: row accepted at edge N gives win_valid=1 from cycle N+1.
// - On win_valid&&win_ready:
//   - win_col++.
//   - At win_col==20: win_col<=0 and win_row++.
//     - If shd is valid: cur<=shd and shd is cleared.
//     - Otherwise: cur_valid<=0.
// - FSM: IDLE -> STREAM on first accepted row (pushed unsolicited by IFMAP memory).
//   - STREAM -> IDLE when the 21st row's last window is consumed.
//   - On that transition: ts_done pulses, and rows_rcvd, win_row, win_col are cleared (next timestep).
// - Request rule (STREAM only):
//   - Raise pkt_out_valid the cycle after all of these hold: shd empty, no request outstanding, rows_rcvd<OUTPUT_SIZE.
//   - pkt_out = {IMEM_ID[3:0], PE_ID[3:0], 25'd0}. Hold it stable until pkt_out_ready.
//   - Outstanding is set on the pkt_out handshake and cleared on the next accepted row.
//   - At most 1 request outstanding. Exactly OUTPUT_SIZE-1=20 requests per timestep.
// - Both buffers full: pkt_in_ready=0 (backpressure into router).
// - Packet arrival and last-column consume in the same cycle: bypass into cur; no bubble.
// - Row arriving in IDLE after timestep 1: starts timestep 2 identically.
// STRUCTURE
// - Shared package ppe_pkg:
//   - packet_t struct {dest[3:0], opcode[3:0], data[24:0]}.
//   - Opcode constants: WEIGHTS_DONE=0, PPE_INPUT=1, TIMESTEP_DONE=15.
//   - Constants IMEM_ID, IFMAP_SIZE, FILTER_SIZE, OUTPUT_SIZE.
//   - FSM enum {IDLE, STREAM}.
// - One sub-module: ifmap_row_dbuf, the 2-entry cur/shd row buffer with bypass.
//   The top level keeps the FSM, counters and request generator.
// TESTING
// 1. Reset: rst_n=0 -> all outputs 0. Release -> pkt_in_ready=1, no pkt_out_valid.
// 2. Push {5,1,25'h000001F}:
//    - Next cycle win_valid=1, win_col=0, win_data=5'b11111.
//    - Next window: win_col=1, win_data=5'b01111.
//    - pkt_out={11,5,0}.
// 3. Full timestep:
//    - Stimulus: win_ready=1; IMEM model answers each request after 10 cycles.
//    - Expect exactly 20 requests and 441 windows.
//    - win_last on the 441st window, then one ts_done pulse, then FSM=IDLE.
// 4. Backpressure:
//    - pkt_out_ready=0 for 20 cycles -> pkt_out stable, no duplicate request.
//    - Both buffers full -> pkt_in_ready=0.
// 5. Bad packet {5,3,x} or {6,1,x} -> accepted, err_pkt=1 for 1 cycle, buffers and counters unchanged.
// 6. Timing edges:
//    - Row arrives in the same cycle as the col-20 consume with shd empty -> next cycle win_col=0 with the new row.
//    - Reset at win_col=10 -> all cleared; the next pushed row starts at win_col=0, win_row=0.

Source files
------------

// File: rtl/ppe_pkg.sv
// Shared PPE definitions: packet layout, opcodes, ifmap geometry and fetch FSM states.
package ppe_pkg;
  localparam int IMEM_ID     = 11;
  localparam int IFMAP_SIZE  = 25;
  localparam int FILTER_SIZE = 5;
  localparam int OUTPUT_SIZE = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int PKT_W       = 33;

  localparam logic [3:0] WEIGHTS_DONE  = 4'd0;
  localparam logic [3:0] PPE_INPUT     = 4'd1;
  localparam logic [3:0] TIMESTEP_DONE = 4'd15;

  typedef struct packed {
    logic [3:0]            dest;
    logic [3:0]            opcode;
    logic [IFMAP_SIZE-1:0] data;
  } packet_t;

  typedef enum logic {IDLE, STREAM} fetch_state_e;
endpackage

// File: rtl/ppe_ifmap_fetch_if.sv
// Router packet handshakes plus the window stream toward the MAC datapath.
interface ppe_ifmap_fetch_if;
  import ppe_pkg::*;

  packet_t                pkt_in;
  logic                   pkt_in_valid;
  logic                   pkt_in_ready;
  packet_t                pkt_out;
  logic                   pkt_out_valid;
  logic                   pkt_out_ready;
  logic [FILTER_SIZE-1:0] win_data;
  logic [4:0]             win_col;
  logic [4:0]             win_row;
  logic                   win_last;
  logic                   win_valid;
  logic                   win_ready;
  logic                   ts_done;
  logic                   err_pkt;

  modport master (
    input  pkt_in, pkt_in_valid, pkt_out_ready, win_ready,
    output pkt_in_ready, pkt_out, pkt_out_valid, win_data, win_col, win_row,
           win_last, win_valid, ts_done, err_pkt
  );

  modport slave (
    output pkt_in, pkt_in_valid, pkt_out_ready, win_ready,
    input  pkt_in_ready, pkt_out, pkt_out_valid, win_data, win_col, win_row,
           win_last, win_valid, ts_done, err_pkt
  );
endinterface

// File: rtl/ppe_ifmap_fetch_dbuf.sv
// Two-entry row buffer: cur feeds the window mux, shd holds the prefetched next row.
module ifmap_row_dbuf
  import ppe_pkg::*;
#(
  parameter int W = IFMAP_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] row,
  input  logic         shift,
  output logic [W-1:0] cur,
  output logic         cur_valid,
  output logic         shd_valid
);
  logic [W-1:0] shd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      shd       <= '0;
      cur_valid <= 1'b0;
      shd_valid <= 1'b0;
    end else if (shift) begin
      // last window of cur consumed: promote shd, else bypass an arriving row
      if (shd_valid) begin
        cur       <= shd;
        shd_valid <= 1'b0;
      end else if (load) begin
        cur <= row;
      end else begin
        cur_valid <= 1'b0;
      end
    end else if (load) begin
      if (!cur_valid) begin
        cur       <= row;
        cur_valid <= 1'b1;
      end else begin
        shd       <= row;
        shd_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ppe_ifmap_fetch.sv
// PPE ifmap requester: double-buffers rows from IFMAP memory, streams sliding
// windows to the MAC datapath and requests one row each time the shadow slot frees.
module ppe_ifmap_fetch
  import ppe_pkg::*;
#(
  parameter int PE_ID = 5
) (
  input logic              clk,
  input logic              rst_n,
  ppe_ifmap_fetch_if.master io
);
  localparam logic [4:0] LAST = 5'(OUTPUT_SIZE - 1);
  localparam packet_t    REQ  = '{dest: 4'(IMEM_ID), opcode: 4'(PE_ID), data: '0};

  fetch_state_e          state, state_nx;
  logic [IFMAP_SIZE-1:0] cur;
  logic                  cur_valid, shd_valid;
  logic [4:0]            win_col, win_row, rows_rcvd;
  logic                  outstanding, pkt_out_valid, ts_done, err_pkt;
  logic                  hs_in, good, load, consume, last_col, shift, ts_end, req_raise, hs_out;

  assign hs_in    = io.pkt_in_valid & ~shd_valid;
  assign good     = (io.pkt_in.dest == 4'(PE_ID)) && (io.pkt_in.opcode == PPE_INPUT);
  assign load     = hs_in & good;
  assign consume  = cur_valid & io.win_ready;
  assign last_col = (win_col == LAST);
  assign shift    = consume & last_col;
  assign ts_end   = (state == STREAM) & shift & (win_row == LAST);
  assign hs_out   = pkt_out_valid & io.pkt_out_ready;

  ifmap_row_dbuf #(.W(IFMAP_SIZE)) u_dbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .row       (io.pkt_in.data),
    .shift     (shift),
    .cur       (cur),
    .cur_valid (cur_valid),
    .shd_valid (shd_valid)
  );

  always_comb begin
    state_nx  = state;
    req_raise = 1'b0;
    case (state)
      IDLE:   if (load) state_nx = STREAM;
      STREAM: begin
        // a row landing on the final consume is the next timestep's first row
        if (ts_end) state_nx = load ? STREAM : IDLE;
        req_raise = !shd_valid && !outstanding && !pkt_out_valid &&
                    (rows_rcvd < 5'(OUTPUT_SIZE));
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      win_col       <= '0;
      win_row       <= '0;
      rows_rcvd     <= '0;
      outstanding   <= 1'b0;
      pkt_out_valid <= 1'b0;
      ts_done       <= 1'b0;
      err_pkt       <= 1'b0;
    end else begin
      state   <= state_nx;
      ts_done <= ts_end;
      err_pkt <= hs_in & ~good;

      if (ts_end) begin
        win_col <= '0;
        win_row <= '0;
      end else if (consume) begin
        if (last_col) begin
          win_col <= '0;
          win_row <= win_row + 5'd1;
        end else begin
          win_col <= win_col + 5'd1;
        end
      end

      if (ts_end)    rows_rcvd <= load ? 5'd1 : 5'd0;
      else if (load) rows_rcvd <= rows_rcvd + 5'd1;

      if (hs_out)         pkt_out_valid <= 1'b0;
      else if (req_raise) pkt_out_valid <= 1'b1;

      if (hs_out)    outstanding <= 1'b1;
      else if (load) outstanding <= 1'b0;
    end
  end

  assign io.pkt_in_ready  = ~shd_valid;
  assign io.pkt_out_valid = pkt_out_valid;
  assign io.pkt_out       = pkt_out_valid ? REQ : '0;
  assign io.win_data      = cur[win_col +: FILTER_SIZE];
  assign io.win_col       = win_col;
  assign io.win_row       = win_row;
  assign io.win_last      = last_col && (win_row == LAST);
  assign io.win_valid     = cur_valid;
  assign io.ts_done       = ts_done;
  assign io.err_pkt       = err_pkt;
endmodule

// File: tb/tb_ppe_ifmap_fetch.sv
// Scoreboarded bench for ppe_ifmap_fetch: rows queued on accept, windows checked on consume.
module tb_ppe_ifmap_fetch;
  import ppe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppe_ifmap_fetch_if io();

  ppe_ifmap_fetch #(.PE_ID(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int n_chk = 0, n_fail = 0;
  int n_win = 0, n_last = 0, n_req = 0, n_ts = 0;
  int m_col = 0, m_row = 0;
  bit err_exp = 0, req_hs = 0;
  logic [24:0] exp_q[$];
  packet_t req_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic packet_t mk(input int d, input int op, input logic [24:0] data);
    packet_t p;
    p.dest = 4'(d); p.opcode = 4'(op); p.data = data;
    return p;
  endfunction

  // Inputs are final on entry; score handshakes of the coming edge, then pulses after it.
  task automatic cyc();
    bit last_win = 0;
    logic [24:0] row;
    if (io.win_valid && io.win_ready) begin
      if (exp_q.size() == 0) chk("win_unexpected", 1, 0);
      else begin
        row = exp_q[0];
        chk("win_data", io.win_data, row[m_col +: 5]);
        chk("win_col", io.win_col, m_col);
        chk("win_row", io.win_row, m_row);
        chk("win_last", io.win_last, (m_col == 20 && m_row == 20));
        n_win++;
        if (io.win_last) n_last++;
        if (m_col == 20) begin
          void'(exp_q.pop_front());
          m_col = 0; m_row++;
          if (m_row == 21) begin m_row = 0; last_win = 1; end
        end else m_col++;
      end
    end
    if (io.pkt_out_valid && io.pkt_out_ready) begin
      n_req++; req_hs = 1;
      chk("pkt_out", io.pkt_out, req_exp);
    end
    @(negedge clk);
    chk("ts_done", io.ts_done, last_win);
    if (io.ts_done) n_ts++;
    chk("err_pkt", io.err_pkt, err_exp);
    err_exp = 0;
  endtask

  task automatic send(input packet_t p);
    int n = 0;
    io.pkt_in = p; io.pkt_in_valid = 1'b1;
    while (!io.pkt_in_ready && n < 200) begin cyc(); n++; end
    if (!io.pkt_in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      if (p.dest == 4'd5 && p.opcode == 4'd1) exp_q.push_back(p.data);
      else err_exp = 1;
      cyc();
    end
    io.pkt_in_valid = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete(); m_col = 0; m_row = 0; err_exp = 0; req_hs = 0;
  endtask

  task automatic do_reset();
    io.pkt_in_valid = 0; io.win_ready = 0; io.pkt_out_ready = 0;
    rst_n = 0; model_clear();
    cyc(); cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic wait_col(input int c);
    int n = 0;
    while (!(io.win_valid && io.win_col == 5'(c)) && n < 200) begin cyc(); n++; end
    chk("wait_col_timeout", (n < 200), 1);
  endtask

  task automatic run_timestep();
    int r0 = n_req, w0 = n_win, l0 = n_last, t0 = n_ts, timer = 0, i = 0;
    io.win_ready = 1; io.pkt_out_ready = 1; req_hs = 0;
    send(mk(5, 1, 25'($urandom)));
    while (n_ts == t0 && i < 5000) begin
      if (req_hs) begin req_hs = 0; timer = 10; end
      if (timer > 0) begin
        timer--;
        if (timer == 0) send(mk(5, 1, 25'($urandom)));
        else cyc();
      end else cyc();
      i++;
    end
    chk("ts_timeout", (n_ts == t0 + 1), 1);
    chk("req_count", n_req - r0, 20);
    chk("win_count", n_win - w0, 441);
    chk("last_count", n_last - l0, 1);
    repeat (5) cyc();
    chk("idle_no_req", io.pkt_out_valid, 0);
    chk("idle_no_win", io.win_valid, 0);
    chk("idle_ready", io.pkt_in_ready, 1);
    chk("idle_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [24:0] rf, rg;
    int r0;
    req_exp = mk(11, 5, 25'd0);
    io.pkt_in = '0; io.pkt_in_valid = 0; io.win_ready = 0; io.pkt_out_ready = 0;

    // reset state
    @(negedge clk);
    chk("rst_win_valid", io.win_valid, 0);
    chk("rst_win_col", io.win_col, 0);
    chk("rst_win_row", io.win_row, 0);
    chk("rst_win_last", io.win_last, 0);
    chk("rst_win_data", io.win_data, 0);
    chk("rst_pkt_out_valid", io.pkt_out_valid, 0);
    chk("rst_pkt_out", io.pkt_out, 0);
    chk("rst_ts_done", io.ts_done, 0);
    chk("rst_err_pkt", io.err_pkt, 0);
    do_reset();
    chk("rel_pkt_in_ready", io.pkt_in_ready, 1);
    chk("rel_pkt_out_valid", io.pkt_out_valid, 0);

    // first row, first windows, request hold under backpressure
    r0 = n_req;
    send(mk(5, 1, 25'h000001F));
    chk("t2_valid", io.win_valid, 1);
    chk("t2_col0", io.win_col, 0);
    chk("t2_data0", io.win_data, 5'b11111);
    io.win_ready = 1; cyc(); io.win_ready = 0;
    chk("t2_col1", io.win_col, 1);
    chk("t2_data1", io.win_data, 5'b01111);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("bp_out_valid", io.pkt_out_valid, 1);
      chk("bp_out_stable", io.pkt_out, req_exp);
    end
    io.pkt_out_ready = 1; cyc();
    for (int i = 0; i < 5; i++) begin cyc(); chk("no_dup_req", io.pkt_out_valid, 0); end
    chk("one_req", n_req - r0, 1);

    // both buffers full
    send(mk(5, 1, 25'($urandom)));
    chk("full_ready", io.pkt_in_ready, 0);
    io.pkt_in = mk(5, 1, 25'h1234567); io.pkt_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("full_ready_hold", io.pkt_in_ready, 0);
      chk("full_no_req", io.pkt_out_valid, 0);
    end
    io.pkt_in_valid = 0;
    io.win_ready = 1;
    repeat (60) cyc();
    chk("drain_q_empty", exp_q.size(), 0);
    do_reset();

    // bad packets
    send(mk(6, 1, 25'($urandom)));
    repeat (3) cyc();
    chk("bad_idle_win", io.win_valid, 0);
    chk("bad_idle_req", io.pkt_out_valid, 0);
    rf = 25'h0ABCDE5;
    send(mk(5, 1, rf));
    send(mk(5, 3, 25'($urandom)));
    chk("bad_ready", io.pkt_in_ready, 1);
    chk("bad_col", io.win_col, 0);
    chk("bad_data", io.win_data, rf[4:0]);
    send(mk(6, 1, 25'($urandom)));
    chk("bad2_ready", io.pkt_in_ready, 1);
    chk("bad2_row", io.win_row, 0);
    do_reset();

    // two full timesteps back to back
    run_timestep();
    run_timestep();
    do_reset();

    // bypass on last-column consume, then reset mid-row
    io.win_ready = 1; io.pkt_out_ready = 1;
    send(mk(5, 1, 25'($urandom)));
    wait_col(20);
    rf = 25'($urandom);
    send(mk(5, 1, rf));
    chk("byp_valid", io.win_valid, 1);
    chk("byp_col", io.win_col, 0);
    chk("byp_row", io.win_row, 1);
    chk("byp_data", io.win_data, rf[4:0]);
    wait_col(10);
    rst_n = 0; #1;
    chk("mid_rst_valid", io.win_valid, 0);
    chk("mid_rst_col", io.win_col, 0);
    chk("mid_rst_req", io.pkt_out_valid, 0);
    chk("mid_rst_ready", io.pkt_in_ready, 1);
    do_reset();
    rg = 25'($urandom);
    send(mk(5, 1, rg));
    chk("post_rst_valid", io.win_valid, 1);
    chk("post_rst_col", io.win_col, 0);
    chk("post_rst_row", io.win_row, 0);
    chk("post_rst_data", io.win_data, rg[4:0]);
    io.win_ready = 1;
    repeat (30) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
